display_digit_scan: RTL and testbench
=====================================

Name: display_digit_scan

Overview:
Upstream feeder for the coffee machine's BCD-to-16-segment digit decoder.
- Accepts a binary amount (credit or price, in cents) on a load strobe.
- Converts it to packed BCD with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the digits onto a single bcd/enable_segment pair and drives a one-hot digit select for the panel.

Parameters:
- DIGITS, 4: number of display digits scanned.
- BIN_W, 14: width of the binary input. Must satisfy 2^BIN_W > 10^DIGITS-1.
- REFRESH_DIV, 50000: clk cycles each digit is held before the scan advances. Must be >= 2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- value  input  BIN_W  binary amount to display; sampled only on an accepted load.
- load  input  1  request to convert and display value.
- blank_lz  input  1  1 = suppress leading zeros; sampled continuously.
- busy  output  1  conversion in progress; load is ignored while high.
- bcd  output  4  BCD code of the currently scanned digit, to the segment decoder.
- enable_segment  output  1  1 = decoder shows this digit, 0 = digit blank.
- digit_sel  output  DIGITS  one-hot active-high digit select. Bit 0 = ones digit.

Behaviour:
- Reset (async assert, sync release):
  - busy=0, bcd=0, enable_segment=0, digit_sel=...0001.
  - Display buffer = 0; valid flag = 0; refresh counter = 0; digit index = 0; FSM = IDLE.
- Control FSM, states IDLE, CONVERT, COMMIT:
  - IDLE: when load=1 at a rising edge:
    - Latch value, saturated to MAX = 10^DIGITS-1 when value > MAX.
    - Clear the BCD accumulator; shift counter = 0; go to CONVERT; busy=1 on the next cycle.
  - CONVERT: one double-dabble iteration per cycle.
    - Add 3 to each BCD nibble >= 5, then shift {bcd_acc, bin} left by 1.
    - After BIN_W iterations go to COMMIT.
  - COMMIT: one cycle.
    - Copy the accumulator into the display buffer; valid=1; busy=0 on the next cycle; go to IDLE.
  - Latency: load accepted at edge k → display buffer updated at edge k+BIN_W+1. busy is high for BIN_W+1 cycles.
  - load while busy=1 is dropped and not queued.
  - load held high continuously: a new conversion starts on the first IDLE edge after each COMMIT.
- Display buffer holds the previous value for the whole conversion. No partial digits ever reach bcd.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1 freely, independent of the FSM.
  - On wrap, digit index advances 0→1→…→DIGITS-1→0.
- Registered outputs, updated every cycle from the current index i:
  - bcd = buffer nibble i.
  - digit_sel = 1<<i.
  - enable_segment = valid AND NOT blanked(i).
  - Outputs lag the index by one cycle.
- Leading-zero blanking:
  - blanked(i) = blank_lz AND i != 0 AND nibbles i..DIGITS-1 are all zero.
  - The ones digit is never blanked, so value 0 shows a single "0".
- Before the first COMMIT after reset, enable_segment stays 0 on every digit.
- rst_n asserted mid-conversion aborts it: the partial result is discarded and all outputs return to reset values.

Decomposition:
- Package display_pkg holds:
  - Constants DISPLAY_DIGITS and MAX_DISPLAY_VALUE (10^DIGITS-1).
  - A 4-bit bcd_digit_t typedef.
  - The FSM state enum {IDLE, CONVERT, COMMIT}.
- One sub-module: bin2bcd_seq.
  - Contains the FSM, saturation and double-dabble datapath.
  - Ports: clk, rst_n, start, bin_in, busy, done, bcd_out.
- display_digit_scan instantiates bin2bcd_seq and owns the display buffer, valid flag, refresh divider, digit index and output registers.

Test Plan:
All scenarios use REFRESH_DIV=4, DIGITS=4, BIN_W=14.
- Reset hold then release, no load:
  - busy=0, enable_segment=0 on all digits.
  - digit_sel cycles 0001→0010→0100→1000→0001, advancing every 4 cycles.
- Load 1234, blank_lz=0:
  - busy high for exactly 15 cycles.
  - Afterwards the scan yields bcd 4,3,2,1 with digit_sel 0001,0010,0100,1000 and enable_segment=1 on each.
- Load 7 with blank_lz=1, then blank_lz=0:
  - With blank_lz=1, only digit_sel=0001 has enable_segment=1, bcd=7; the other three digits have enable_segment=0.
  - With blank_lz=0, all four digits are enabled, showing 7,0,0,0.
- Load 12000:
  - Displays 9,9,9,9.
  - Then load 0 with blank_lz=1: ones digit shows 0 enabled, others blank.
- Load 1234, then pulse load with value=5678 at cycle 5 of busy:
  - The second request is ignored; display shows 1234; busy falls after 15 cycles.
- Load 5678 after 1234 is displayed, then assert rst_n=0 at cycle 8 of busy:
  - All outputs return to reset values; enable_segment=0; a subsequent load 42 displays 2,4.

Source files
------------

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and constants for the digit scan display
// Purpose: default digit count, display ceiling, BCD digit type and converter FSM states.
// Ports: none (package).
package display_pkg;

  localparam int DISPLAY_DIGITS    = 4;
  localparam int MAX_DISPLAY_VALUE = 10**DISPLAY_DIGITS - 1;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COMMIT
  } conv_state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 binary to packed BCD converter
// Purpose: saturates the input to 10^DIGITS-1, then runs one double-dabble step per cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request a conversion (honoured only in IDLE)
//   bin_in     : binary value, captured on an accepted start
//   busy       : high from the cycle after acceptance through COMMIT
//   done       : high during COMMIT; bcd_out is final in that cycle
//   bcd_out    : packed BCD accumulator, ones digit in bits [3:0]
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = DISPLAY_DIGITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin_in,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd_out
);

  localparam int BCD_W   = 4 * DIGITS;
  localparam int CNT_W   = $clog2(BIN_W + 1);
  localparam int MAX_INT = 10**DIGITS - 1;
  localparam logic [BIN_W-1:0] MAX_BIN   = BIN_W'(MAX_INT);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  conv_state_t        r_state;
  conv_state_t        w_next;
  logic [BIN_W-1:0]   r_bin;
  logic [BCD_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [BCD_W-1:0]   w_adj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = CONVERT;
      end
      CONVERT: begin
        busy = 1'b1;
        if (r_cnt == LAST_ITER) w_next = COMMIT;
      end
      COMMIT: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Add-3 correction so each nibble carries into the next decade after the shift.
  always_comb begin
    w_adj = r_acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_acc[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bin <= (bin_in > MAX_BIN) ? MAX_BIN : bin_in;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        CONVERT: begin
          {r_acc, r_bin} <= {w_adj, r_bin} << 1;
          r_cnt          <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bcd_out = r_acc;

endmodule

// File: rtl/display_digit_scan.sv
// rtl/display_digit_scan.sv - binary amount to multiplexed BCD digit scan for the segment decoder
// Purpose: converts a loaded amount to BCD, holds it in a display buffer and scans it digit by digit.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   value, load     : amount to show and its load strobe (dropped while busy)
//   blank_lz        : suppress leading zeros (ones digit always shown)
//   busy            : conversion in progress
//   bcd             : BCD code of the scanned digit
//   enable_segment  : 1 = show the scanned digit, 0 = blank
//   digit_sel       : one-hot digit select, bit 0 = ones digit
module display_digit_scan
  import display_pkg::*;
#(
  parameter int DIGITS      = DISPLAY_DIGITS,
  parameter int BIN_W       = 14,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BIN_W-1:0]  value,
  input  logic              load,
  input  logic              blank_lz,
  output logic              busy,
  output bcd_digit_t        bcd,
  output logic              enable_segment,
  output logic [DIGITS-1:0] digit_sel
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [REF_W-1:0]  REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] SEL_ONE  = DIGITS'(1);

  logic               w_busy;
  logic               w_done;
  logic [BCD_W-1:0]   w_acc;
  logic               w_upper_zero;
  logic               w_blank;

  logic [BCD_W-1:0]   r_buf;
  logic               r_valid;
  logic [REF_W-1:0]   r_ref_cnt;
  logic [IDX_W-1:0]   r_idx;
  bcd_digit_t         r_bcd;
  logic               r_en;
  logic [DIGITS-1:0]  r_sel;

  bin2bcd_seq #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (load),
    .bin_in  (value),
    .busy    (w_busy),
    .done    (w_done),
    .bcd_out (w_acc)
  );

  // The buffer only changes on COMMIT, so the scan never sees a partial conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf   <= '0;
      r_valid <= 1'b0;
    end else if (w_done) begin
      r_buf   <= w_acc;
      r_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref_cnt <= '0;
      r_idx     <= '0;
    end else if (r_ref_cnt == REF_LAST) begin
      r_ref_cnt <= '0;
      r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_ref_cnt <= r_ref_cnt + REF_W'(1);
    end
  end

  // True when the scanned digit and every more significant digit are zero.
  always_comb begin
    w_upper_zero = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (d >= int'(r_idx) && r_buf[4*d +: 4] != 4'd0) w_upper_zero = 1'b0;
    end
  end

  assign w_blank = blank_lz && (r_idx != '0) && w_upper_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd <= '0;
      r_en  <= 1'b0;
      r_sel <= SEL_ONE;
    end else begin
      r_bcd <= r_buf[4*r_idx +: 4];
      r_en  <= r_valid && !w_blank;
      r_sel <= SEL_ONE << r_idx;
    end
  end

  assign busy           = w_busy;
  assign bcd            = r_bcd;
  assign enable_segment = r_en;
  assign digit_sel      = r_sel;

endmodule

// File: tb/tb_display_digit_scan.sv
// tb/tb_display_digit_scan.sv - scoreboard bench for display_digit_scan
module tb_display_digit_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] value;
  logic        load;
  logic        blank_lz;
  logic        busy;
  logic [3:0]  bcd;
  logic        enable_segment;
  logic [3:0]  digit_sel;

  always #5 clk = ~clk;

  display_digit_scan #(
    .DIGITS      (4),
    .BIN_W       (14),
    .REFRESH_DIV (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .value          (value),
    .load           (load),
    .blank_lz       (blank_lz),
    .busy           (busy),
    .bcd            (bcd),
    .enable_segment (enable_segment),
    .digit_sel      (digit_sel)
  );

  typedef struct packed {
    logic [3:0] sel;
    logic       en;
    logic [3:0] bcd;
  } exp_t;

  exp_t exp_q[$];
  int   busy_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  task automatic push_exp(input logic [3:0] s, input logic e, input logic [3:0] b);
    exp_t x;
    x.sel = s;
    x.en  = e;
    x.bcd = b;
    exp_q.push_back(x);
  endtask

  // Monitor: each newly presented digit is checked against the scoreboard,
  // scan period and busy pulse length are measured independently.
  logic [3:0] prev_sel = 4'b0001;
  int         since    = 0;
  bit         have_ref = 1'b0;
  int         blen     = 0;

  always @(negedge clk) begin
    exp_t e;
    int   want;
    if (!rst_n) begin
      prev_sel = digit_sel;
      have_ref = 1'b0;
      since    = 0;
      blen     = 0;
    end else begin
      since++;
      if (digit_sel != prev_sel) begin
        if (have_ref) check("scan_interval", since, 4);
        have_ref = 1'b1;
        since    = 0;
        prev_sel = digit_sel;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("digit_sel", int'(digit_sel), int'(e.sel));
          check("enable_segment", int'(enable_segment), int'(e.en));
          check("bcd", int'(bcd), int'(e.bcd));
        end
      end
      if (busy) begin
        blen++;
      end else if (blen > 0) begin
        if (busy_q.size() > 0) begin
          want = busy_q.pop_front();
          check("busy_len", blen, want);
        end else begin
          check("unexpected_busy_pulse", blen, 0);
        end
        blen = 0;
      end
    end
  end

  task automatic do_load(input int v, input bit expect_busy);
    if (expect_busy) busy_q.push_back(15);
    @(negedge clk);
    value = 14'(v);
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", int'(busy), 0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic show(input logic [3:0] d3, input logic [3:0] d2,
                      input logic [3:0] d1, input logic [3:0] d0,
                      input logic [3:0] en);
    int n = 0;
    wait_idle();
    do begin
      @(negedge clk);
      n++;
    end while (digit_sel != 4'b1000 && n < 40);
    check("sel_sync", int'(digit_sel), 8);
    @(posedge clk);
    push_exp(4'b0001, en[0], d0);
    push_exp(4'b0010, en[1], d1);
    push_exp(4'b0100, en[2], d2);
    push_exp(4'b1000, en[3], d3);
    wait_drain();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_en"}, int'(enable_segment), 0);
    check({tag, "_sel"}, int'(digit_sel), 1);
    check({tag, "_bcd"}, int'(bcd), 0);
  endtask

  task automatic expect_dark_scan();
    push_exp(4'b0010, 1'b0, 4'd0);
    push_exp(4'b0100, 1'b0, 4'd0);
    push_exp(4'b1000, 1'b0, 4'd0);
    push_exp(4'b0001, 1'b0, 4'd0);
    wait_drain();
  endtask

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    value    = '0;
    blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    expect_dark_scan();

    blank_lz = 1'b0;
    do_load(1234, 1'b1);
    show(4'd1, 4'd2, 4'd3, 4'd4, 4'b1111);

    blank_lz = 1'b1;
    do_load(7, 1'b1);
    show(4'd0, 4'd0, 4'd0, 4'd7, 4'b0001);
    blank_lz = 1'b0;
    show(4'd0, 4'd0, 4'd0, 4'd7, 4'b1111);

    do_load(12000, 1'b1);
    show(4'd9, 4'd9, 4'd9, 4'd9, 4'b1111);
    blank_lz = 1'b1;
    do_load(0, 1'b1);
    show(4'd0, 4'd0, 4'd0, 4'd0, 4'b0001);

    blank_lz = 1'b0;
    do_load(1234, 1'b1);
    repeat (4) @(negedge clk);
    value = 14'd5678;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    show(4'd1, 4'd2, 4'd3, 4'd4, 4'b1111);

    do_load(5678, 1'b0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("abort");
    rst_n = 1'b1;
    expect_dark_scan();

    blank_lz = 1'b1;
    do_load(42, 1'b1);
    show(4'd0, 4'd0, 4'd4, 4'd2, 4'b0011);

    repeat (4) @(negedge clk);
    check("busy_queue_empty", busy_q.size(), 0);
    check("exp_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
